// File: rtl/cam_client.sv
// cam_client: sequences LOOKUP/READ/WRITE/LOOKUP_INSERT requests onto a
// 32x32 CAM port, allocating round-robin on insert misses.
module cam_client #(
  parameter int CAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_index,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [4:0]  rsp_index,
  output logic [31:0] rsp_data,
  output logic        rsp_evict,
  output logic [5:0]  occupancy,
  output logic        cam_read,
  output logic [4:0]  cam_read_index,
  output logic        cam_write,
  output logic [4:0]  cam_write_index,
  output logic [31:0] cam_write_data,
  output logic        cam_search,
  output logic [31:0] cam_search_data,
  input  logic        cam_read_valid,
  input  logic [31:0] cam_read_value,
  input  logic        cam_search_valid,
  input  logic [4:0]  cam_search_index
);

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] OP_INSERT = 2'd3;
  localparam logic [1:0] LAT_M1    = 2'(CAM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ALLOC,
    RESP
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [4:0]  idx_q;
  logic [31:0] key_q;
  logic [1:0]  cnt_q;
  logic [4:0]  ptr_q;
  logic [4:0]  ptr_d;
  logic [5:0]  occ_q;
  logic [5:0]  occ_d;

  logic        rsp_valid_q;
  logic        rsp_hit_q;
  logic [4:0]  rsp_index_q;
  logic [31:0] rsp_data_q;
  logic        rsp_evict_q;

  logic        cam_read_q;
  logic [4:0]  cam_read_index_q;
  logic        cam_write_q;
  logic [4:0]  cam_write_index_q;
  logic [31:0] cam_write_data_q;
  logic        cam_search_q;
  logic [31:0] cam_search_data_q;

  logic        accept;
  logic        full;
  logic        ins_miss;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign full      = (occ_q == 6'd32);
  assign ptr_d     = ptr_q + 5'd1;
  assign occ_d     = full ? occ_q : occ_q + 6'd1;
  assign ins_miss  = (op_q == OP_INSERT) && !cam_search_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      op_q              <= OP_LOOKUP;
      idx_q             <= '0;
      key_q             <= '0;
      cnt_q             <= '0;
      ptr_q             <= '0;
      occ_q             <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_hit_q         <= 1'b0;
      rsp_index_q       <= '0;
      rsp_data_q        <= '0;
      rsp_evict_q       <= 1'b0;
      cam_read_q        <= 1'b0;
      cam_read_index_q  <= '0;
      cam_write_q       <= 1'b0;
      cam_write_index_q <= '0;
      cam_write_data_q  <= '0;
      cam_search_q      <= 1'b0;
      cam_search_data_q <= '0;
    end else begin
      // strobes are single-cycle pulses
      cam_read_q   <= 1'b0;
      cam_write_q  <= 1'b0;
      cam_search_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q        <= req_op;
            idx_q       <= req_index;
            key_q       <= req_data;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            rsp_evict_q <= 1'b0;
            state_q     <= ISSUE;
            unique case (req_op)
              OP_READ: begin
                cam_read_q       <= 1'b1;
                cam_read_index_q <= req_index;
              end
              OP_WRITE: begin
                cam_write_q       <= 1'b1;
                cam_write_index_q <= req_index;
                cam_write_data_q  <= req_data;
              end
              default: begin
                cam_search_q      <= 1'b1;
                cam_search_data_q <= req_data;
              end
            endcase
          end
        end
        ISSUE: begin
          if (op_q == OP_WRITE) begin
            rsp_hit_q   <= 1'b1;
            rsp_index_q <= idx_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else if (op_q == OP_READ) begin
            rsp_hit_q   <= cam_read_valid;
            rsp_data_q  <= cam_read_value;
            rsp_index_q <= idx_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (ins_miss) begin
            cam_write_q       <= 1'b1;
            cam_write_index_q <= ptr_q;
            cam_write_data_q  <= key_q;
            rsp_hit_q         <= 1'b0;
            rsp_index_q       <= ptr_q;
            rsp_evict_q       <= full;
            state_q           <= ALLOC;
          end else begin
            rsp_hit_q   <= cam_search_valid;
            rsp_index_q <= cam_search_valid ? cam_search_index : 5'd0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        ALLOC: begin
          ptr_q       <= ptr_d;
          occ_q       <= occ_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_hit         = rsp_hit_q;
  assign rsp_index       = rsp_index_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_evict       = rsp_evict_q;
  assign occupancy       = occ_q;
  assign cam_read        = cam_read_q;
  assign cam_read_index  = cam_read_index_q;
  assign cam_write       = cam_write_q;
  assign cam_write_index = cam_write_index_q;
  assign cam_write_data  = cam_write_data_q;
  assign cam_search      = cam_search_q;
  assign cam_search_data = cam_search_data_q;

endmodule

// File: tb/tb_cam_client.sv
// tb_cam_client: two DUTs (CAM_LAT 1 and 3), each with a CAM model and
// a table-level reference of expected responses, latency and strobes.
module tb_cam_client;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done [2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        reset = 1'b1;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_index;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_ready, rsp_hit, rsp_evict;
    logic [4:0]  rsp_index;
    logic [31:0] rsp_data;
    logic [5:0]  occupancy;
    logic        cam_read, cam_write, cam_search;
    logic [4:0]  cam_read_index, cam_write_index;
    logic [31:0] cam_write_data, cam_search_data;
    logic        cam_read_valid, cam_search_valid;
    logic [31:0] cam_read_value;
    logic [4:0]  cam_search_index;

    cam_client #(.CAM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_index(req_index), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hit(rsp_hit), .rsp_index(rsp_index),
      .rsp_data(rsp_data), .rsp_evict(rsp_evict),
      .occupancy(occupancy),
      .cam_read(cam_read), .cam_read_index(cam_read_index),
      .cam_write(cam_write), .cam_write_index(cam_write_index),
      .cam_write_data(cam_write_data),
      .cam_search(cam_search), .cam_search_data(cam_search_data),
      .cam_read_valid(cam_read_valid), .cam_read_value(cam_read_value),
      .cam_search_valid(cam_search_valid),
      .cam_search_index(cam_search_index)
    );

    // CAM: contents plus a LAT-deep result delay line
    bit [31:0] mem [32];
    bit [31:0] vld;
    bit [32:0] rpipe [LAT];
    bit [5:0]  spipe [LAT];

    function automatic bit [5:0] find(input bit [31:0] k);
      for (int i = 0; i < 32; i++)
        if (vld[i] && mem[i] == k) return {1'b1, 5'(i)};
      return 6'd0;
    endfunction

    always @(posedge clk) begin
      if (cam_write) begin
        mem[cam_write_index] <= cam_write_data;
        vld[cam_write_index] <= 1'b1;
      end
      rpipe[0] <= {cam_read & vld[cam_read_index], mem[cam_read_index]};
      spipe[0] <= cam_search ? find(cam_search_data) : 6'd0;
      for (int k = 1; k < LAT; k++) begin
        rpipe[k] <= rpipe[k-1];
        spipe[k] <= spipe[k-1];
      end
    end

    assign cam_read_valid   = rpipe[LAT-1][32];
    assign cam_read_value   = rpipe[LAT-1][31:0];
    assign cam_search_valid = spipe[LAT-1][5];
    assign cam_search_index = spipe[LAT-1][4:0];

    // reference view of the table and allocator
    bit [31:0] rmem [32];
    bit [31:0] rvld;
    int rptr = 0;
    int rocc = 0;
    logic        ghit, gev;
    logic [4:0]  gidx;
    logic [31:0] gdata;
    logic [5:0]  gocc;

    task automatic ck(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      chk($sformatf("L%0d %s", LAT, nm), got, exp);
    endtask

    task automatic junk();
      req_valid = 1'($urandom);
      req_op    = 2'($urandom);
      req_index = 5'($urandom);
      req_data  = $urandom;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [4:0] idx,
                         input logic [31:0] d, input int hold);
      int m;
      int lat;
      bit alloc;
      logic e_hit, e_ev;
      logic [4:0] e_idx;
      logic [31:0] e_data;
      logic [2:0] s1, se;
      m = -1;
      for (int i = 0; i < 32; i++)
        if (m < 0 && rvld[i] && rmem[i] == d) m = i;
      alloc  = 1'b0;
      e_data = '0;
      e_ev   = 1'b0;
      lat    = 2 + LAT;
      e_hit  = (m >= 0);
      e_idx  = (m >= 0) ? 5'(m) : 5'd0;
      s1     = 3'b100;
      case (op)
        2'd1: begin
          e_hit = rvld[idx]; e_idx = idx; e_data = rmem[idx]; s1 = 3'b010;
        end
        2'd2: begin
          e_hit = 1'b1; e_idx = idx; lat = 2; s1 = 3'b001;
        end
        2'd3: if (m < 0) begin
          alloc = 1'b1; e_idx = 5'(rptr); e_ev = (rocc == 32); lat = 3 + LAT;
        end
        default: ;
      endcase
      ck("idle ready", req_ready, 1);
      ck("occ before", occupancy, 32'(rocc));
      req_valid = 1'b1; req_op = op; req_index = idx; req_data = d;
      rsp_ready = 1'b0;
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        junk();
        se = (c == 1) ? s1 : (alloc && c == 2 + LAT) ? 3'b001 : 3'b000;
        ck("strobes", {cam_search, cam_read, cam_write}, se);
        if (c == 1) begin
          if (op == 2'd1) ck("rd idx", cam_read_index, idx);
          else if (op == 2'd2) begin
            ck("wr idx", cam_write_index, idx);
            ck("wr data", cam_write_data, d);
          end else ck("srch key", cam_search_data, d);
        end
        if (alloc && c == 2 + LAT) begin
          ck("alloc idx", cam_write_index, e_idx);
          ck("alloc data", cam_write_data, d);
        end
        ck("rsp_valid", rsp_valid, c == lat);
        ck("busy ready", req_ready, 0);
      end
      if (op == 2'd2) begin rmem[idx] = d; rvld[idx] = 1'b1; end
      if (alloc) begin
        rmem[rptr] = d; rvld[rptr] = 1'b1;
        rptr = (rptr + 1) % 32;
        rocc = (rocc < 32) ? rocc + 1 : 32;
      end
      for (int h = 0; h <= hold; h++) begin
        if (h > 0) begin
          @(negedge clk);
          junk();
          ck("hold valid", rsp_valid, 1);
          ck("hold ready", req_ready, 0);
          ck("hold strobes", {cam_search, cam_read, cam_write}, 0);
        end
        ck("rsp hit", rsp_hit, e_hit);
        ck("rsp idx", rsp_index, e_idx);
        ck("rsp data", rsp_data, e_data);
        ck("rsp evict", rsp_evict, e_ev);
        ck("rsp occ", occupancy, 32'(rocc));
      end
      ghit = rsp_hit; gidx = rsp_index; gdata = rsp_data;
      gev = rsp_evict; gocc = occupancy;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      ck("post valid", rsp_valid, 0);
      ck("post ready", req_ready, 1);
      ck("post strobes", {cam_search, cam_read, cam_write}, 0);
    endtask

    task automatic reset_mid(input int at, input logic [31:0] key);
      ck("rm ready", req_ready, 1);
      req_valid = 1'b1; req_op = 2'd3; req_index = '0; req_data = key;
      for (int c = 1; c <= at; c++) begin
        @(negedge clk);
        junk();
      end
      ck("rm pre strobe", {cam_search, cam_read, cam_write},
         (at == 2 + LAT) ? 3'b001 : 3'b000);
      #2 reset = 1'b1;
      req_valid = 1'b0;
      #1;
      ck("rm strobes", {cam_search, cam_read, cam_write}, 0);
      ck("rm valid", rsp_valid, 0);
      ck("rm no accept", req_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      rptr = 0;
      rocc = 0;
      ck("rm occ", occupancy, 0);
      for (int c = 0; c < LAT + 4; c++) begin
        @(negedge clk);
        ck("rm no rsp", rsp_valid, 0);
        ck("rm ready after", req_ready, 1);
        ck("rm idle strobes", {cam_search, cam_read, cam_write}, 0);
      end
    endtask

    initial begin
      req_valid = 1'b0; req_op = '0; req_index = '0; req_data = '0;
      rsp_ready = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      ck("rst valid", rsp_valid, 0);
      ck("rst occ", occupancy, 0);
      ck("rst strobes", {cam_search, cam_read, cam_write}, 0);
      ck("rst fields", {rsp_hit, rsp_evict, rsp_index}, 0);
      ck("rst data", rsp_data, 0);
      ck("rst no accept", req_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      ck("rel ready", req_ready, 1);

      do_op(2'd2, 5'd5, 32'hDEADBEEF, 0);
      ck("lit w hit", ghit, 1); ck("lit w idx", gidx, 5);
      do_op(2'd0, 5'd0, 32'hDEADBEEF, 1);
      ck("lit lk hit", ghit, 1); ck("lit lk idx", gidx, 5);
      do_op(2'd0, 5'd0, 32'h12345678, 0);
      ck("lit miss hit", ghit, 0); ck("lit miss idx", gidx, 0);
      do_op(2'd1, 5'd5, 32'h0, 0);
      ck("lit rd data", gdata, 32'hDEADBEEF); ck("lit rd hit", ghit, 1);
      do_op(2'd1, 5'd9, 32'h0, 0);
      ck("lit rd inval", ghit, 0);
      for (int i = 0; i < 33; i++) begin
        do_op(2'd3, 5'd0, 32'h5000_0000 + 32'(i), 0);
        ck("lit ins idx", gidx, 32'(i % 32));
        ck("lit ins evict", gev, 32'(i == 32));
        ck("lit ins occ", gocc, 32'((i < 32) ? i + 1 : 32));
      end
      do_op(2'd3, 5'd0, 32'h5000_0001, 0);
      ck("lit ins hit", ghit, 1); ck("lit ins hit idx", gidx, 1);
      do_op(2'd3, 5'd0, 32'h5100_0000, 0);
      ck("lit ptr kept", gidx, 1); ck("lit ptr evict", gev, 1);
      do_op(2'd0, 5'd0, 32'h5000_0005, 10);
      ck("lit hold idx", gidx, 5);

      for (int n = 0; n < 150; n++) begin
        do_op(2'($urandom_range(0, 3)), 5'($urandom),
              32'h5000_0000 + 32'($urandom_range(0, 40)),
              ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 2)));
      end

      reset_mid(2, 32'h7700_0000);
      do_op(2'd3, 5'd0, 32'h7800_0000, 0);
      ck("lit rst idx", gidx, 0); ck("lit rst occ", gocc, 1);
      reset_mid(2 + LAT, 32'h7700_0001);
      do_op(2'd3, 5'd0, 32'h7800_0001, 0);
      ck("lit rst2 idx", gidx, 0); ck("lit rst2 evict", gev, 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
